// File: rtl/rr_mux4_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
package rr_mux4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int NREQ   = 4;
    localparam int DW     = 4;
    localparam int GCNT_W = 8;

endpackage

// File: rtl/rr_mux4_arbiter_pick4.sv
// Rotating priority pick: first set request bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx,
    output logic [3:0] onehot
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        any    = |req;
        idx    = ptr;
        found  = 1'b0;
        cand   = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        onehot = any ? (4'b0001 << idx) : 4'b0000;
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4-bit 4:1 data path among four requesters.
// Optional per-requester grant counters on GCNT when RR_MUX4_GRANT_CNT_EN is defined.
module rr_mux4_arbiter
    import rr_mux4_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [3:0]    REQ,
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] D1,
    input  logic [DW-1:0] D2,
    input  logic [DW-1:0] D3,
    output logic [3:0]    GNT,
    output logic [1:0]    SEL,
    output logic [DW-1:0] Y,
    output logic          VALID,
    output logic          dbg_state
`ifdef RR_MUX4_GRANT_CNT_EN
    ,
    output logic [31:0]   GCNT
`endif
);

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic              grant_evt;

    logic              idle_any, ho_any;
    logic [1:0]        idle_idx, ho_idx;
    logic [3:0]        idle_oh, ho_oh;
    logic [3:0]        req_other;
    logic [1:0]        ptr_after;
    logic              hold_lim;

    assign req_other = REQ & ~gnt_q;
    assign ptr_after = sel_q + 2'd1;
    assign hold_lim  = (hcnt_q == CNT_W'(MAX_HOLD - 1));

    rr_pick4 u_pick_idle (
        .req    (REQ),
        .ptr    (ptr_q),
        .any    (idle_any),
        .idx    (idle_idx),
        .onehot (idle_oh)
    );

    // Handover pick excludes the current owner and starts just past it.
    rr_pick4 u_pick_handover (
        .req    (req_other),
        .ptr    (ptr_after),
        .any    (ho_any),
        .idx    (ho_idx),
        .onehot (ho_oh)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        hcnt_d    = hcnt_q;
        grant_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_any) begin
                    state_d   = GRANT;
                    sel_d     = idle_idx;
                    gnt_d     = idle_oh;
                    hcnt_d    = '0;
                    grant_evt = 1'b1;
                end
            end
            GRANT: begin
                if (!REQ[sel_q] || (hold_lim && ho_any)) begin
                    ptr_d = ptr_after;
                    if (ho_any) begin
                        sel_d     = ho_idx;
                        gnt_d     = ho_oh;
                        hcnt_d    = '0;
                        grant_evt = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sel_d   = 2'd0;
                        gnt_d   = 4'b0000;
                        hcnt_d  = '0;
                    end
                end else if (hold_lim) begin
                    hcnt_d    = '0;
                    grant_evt = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                sel_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // VALID marks Y as carrying the granted word this cycle; there is no
    // back-pressure, the consumer takes Y whenever VALID is high.
    logic [DW-1:0] word;
    always_comb begin
        case (sel_q)
            2'd0:    word = D0;
            2'd1:    word = D1;
            2'd2:    word = D2;
            default: word = D3;
        endcase
    end

    assign VALID     = (state_q == GRANT);
    assign Y         = VALID ? word : '0;
    assign GNT       = gnt_q;
    assign SEL       = sel_q;
    assign dbg_state = state_q;

`ifdef RR_MUX4_GRANT_CNT_EN
    logic [GCNT_W-1:0] gcnt_q [NREQ];
    logic [GCNT_W-1:0] gcnt_d [NREQ];

    always_comb begin
        gcnt_d = gcnt_q;
        if (grant_evt && (gcnt_q[sel_d] != {GCNT_W{1'b1}})) begin
            gcnt_d[sel_d] = gcnt_q[sel_d] + GCNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREQ; i++) gcnt_q[i] <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign GCNT = {gcnt_q[3], gcnt_q[2], gcnt_q[1], gcnt_q[0]};
`endif

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed plus randomized bench for rr_mux4_arbiter against a rule-level reference model.
module tb_rr_mux4_arbiter;

    localparam int MH = 4;

    logic       CLK;
    logic       RST_N;
    logic [3:0] REQ;
    logic [3:0] D0, D1, D2, D3;
    logic [3:0] GNT;
    logic [1:0] SEL;
    logic [3:0] Y;
    logic       VALID;
    logic       dbg_state;
`ifdef RR_MUX4_GRANT_CNT_EN
    logic [31:0] GCNT;
`endif

    rr_mux4_arbiter #(.MAX_HOLD(MH), .CNT_W(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .GNT       (GNT),
        .SEL       (SEL),
        .Y         (Y),
        .VALID     (VALID),
        .dbg_state (dbg_state)
`ifdef RR_MUX4_GRANT_CNT_EN
        ,
        .GCNT      (GCNT)
`endif
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    // reference model: owner index (-1 = idle), pointer, hold cycles, grant counts
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_gcnt [4];

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] data_of(input int i);
        case (i)
            0:       return D0;
            1:       return D1;
            2:       return D2;
            default: return D3;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        for (int i = 0; i < 4; i++) m_gcnt[i] = 0;
    endtask

    task automatic count_grant(input int i);
        if (m_gcnt[i] < 255) m_gcnt[i] = m_gcnt[i] + 1;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] others;
        if (m_owner < 0) begin
            if (r != 4'b0000) begin
                m_owner = pick(r, m_ptr);
                m_hold  = 0;
                count_grant(m_owner);
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner] || (m_hold == MH - 1 && others != 4'b0000)) begin
                m_ptr = (m_owner + 1) % 4;
                if (others != 4'b0000) begin
                    m_owner = pick(others, m_ptr);
                    m_hold  = 0;
                    count_grant(m_owner);
                end else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (m_hold == MH - 1) begin
                m_hold = 0;
                count_grant(m_owner);
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        logic [3:0] e_gnt;
        logic [3:0] e_y;
        e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e_y   = (m_owner >= 0) ? data_of(m_owner) : 4'b0000;
        check("gnt", 32'(GNT), 32'(e_gnt));
        check("valid", 32'(VALID), 32'(m_owner >= 0));
        check("state", 32'(dbg_state), 32'(m_owner >= 0));
        check("y", 32'(Y), 32'(e_y));
        if (m_owner >= 0) check("sel", 32'(SEL), 32'(m_owner));
`ifdef RR_MUX4_GRANT_CNT_EN
        for (int i = 0; i < 4; i++) check("gcnt", 32'(GCNT[8*i +: 8]), 32'(m_gcnt[i]));
`endif
    endtask

    // driver: apply REQ, clock once, compare, return at the falling edge
    task automatic step(input logic [3:0] r);
        REQ = r;
        @(posedge CLK);
        model_step(r);
        #1;
        check_outputs();
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        #1;
        model_reset();
        check("rst_gnt", 32'(GNT), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_y", 32'(Y), 32'h0);
        check("rst_sel", 32'(SEL), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        REQ   = 4'b0000;
        D0 = 4'h0; D1 = 4'h0; D2 = 4'h0; D3 = 4'h0;
        model_reset();
        repeat (2) @(negedge CLK);
        apply_reset();

        // single requester held with no competition
        D2 = 4'hA;
        repeat (10) step(4'b0100);
        check("single_y", 32'(Y), 32'hA);
        step(4'b0000);

        // full contention from a fresh pointer
        apply_reset();
        D0 = 4'h1; D1 = 4'h2; D2 = 4'h3; D3 = 4'h4;
        step(4'b1111);
        check("cont_first", 32'(GNT), 32'h1);
        repeat (19) step(4'b1111);
        step(4'b0000);

        // voluntary handover from owner 1 to 3 without a bubble
        step(4'b0010);
        step(4'b1010);
        step(4'b1000);
        check("handover_gnt", 32'(GNT), 32'h8);
        check("handover_valid", 32'(VALID), 32'h1);
        step(4'b0000);
        check("drop_all", 32'(GNT), 32'h0);

        // pointer wraps past 3 to requester 0
        step(4'b0100);
        step(4'b0000);
        step(4'b0011);
        check("wrap_first", 32'(GNT), 32'h1);
        step(4'b0010);
        check("wrap_second", 32'(GNT), 32'h2);
        step(4'b0000);

        // asynchronous reset in the middle of a grant to 2
        step(4'b0100);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check("midrst_gnt", 32'(GNT), 32'h0);
        check("midrst_valid", 32'(VALID), 32'h0);
        check("midrst_y", 32'(Y), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        step(4'b1111);
        check("postrst_gnt", 32'(GNT), 32'h1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            D0 = 4'($urandom_range(0, 15));
            D1 = 4'($urandom_range(0, 15));
            D2 = 4'($urandom_range(0, 15));
            D3 = 4'($urandom_range(0, 15));
            step(4'($urandom_range(0, 15)));
        end

`ifdef RR_MUX4_GRANT_CNT_EN
        // long contention drives every counter into saturation
        repeat (4200) step(4'b1111);
        for (int i = 0; i < 4; i++) check("gcnt_sat", 32'(GCNT[8*i +: 8]), 32'd255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
